// File: rtl/reg_file_mp_if.sv
// Bus bundle for reg_file_mp: read ports, two write ports, issue strobe and busy count.
// The testbench/pipeline drives through the master modport; the register file uses slave.
interface reg_file_mp_if #(
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter int NUM_RD = 3
);
  logic [NUM_RD*AW-1:0] raddr;
  logic [NUM_RD*DW-1:0] rdata;
  logic [NUM_RD-1:0]    rbusy;
  logic                 we0;
  logic [AW-1:0]        wa0;
  logic [DW-1:0]        wd0;
  logic                 we1;
  logic [AW-1:0]        wa1;
  logic [DW-1:0]        wd1;
  logic                 iss_en;
  logic [AW-1:0]        iss_addr;
  logic [AW:0]          busy_cnt;

  modport master (
    output raddr, we0, wa0, wd0, we1, wa1, wd1, iss_en, iss_addr,
    input  rdata, rbusy, busy_cnt
  );

  modport slave (
    input  raddr, we0, wa0, wd0, we1, wa1, wd1, iss_en, iss_addr,
    output rdata, rbusy, busy_cnt
  );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port register file with two prioritised write ports, optional write bypass,
// optional hardwired zero register and a per-register busy scoreboard. Optional trace: REG_FILE_MP_TRACE_EN.
module reg_file_mp #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int NUM_RD   = 3,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  reg_file_mp_if.slave  bus
);
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0]    regs_q [DEPTH];
  logic [DW-1:0]    regs_d [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic [AW:0]      busy_cnt_q;
  logic [AW:0]      busy_cnt_d;
  logic             wr0_ok;
  logic             wr1_ok;

  function automatic logic writable(input logic [AW-1:0] a);
    return (ZERO_REG == 1'b0) || (a != '0);
  endfunction

  assign wr0_ok = bus.we0 && writable(bus.wa0);
  assign wr1_ok = bus.we1 && writable(bus.wa1);

  // Port 1 is applied last so it wins a same-address collision.
  always_comb begin
    regs_d = regs_q;
    if (wr0_ok) regs_d[bus.wa0] = bus.wd0;
    if (wr1_ok) regs_d[bus.wa1] = bus.wd1;
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_busy
      localparam logic [AW-1:0] ADDR = AW'(gi);
      logic set_r;
      logic clr_r;
      assign set_r = bus.iss_en && (bus.iss_addr == ADDR) && writable(ADDR);
      assign clr_r = (bus.we0 && (bus.wa0 == ADDR)) || (bus.we1 && (bus.wa1 == ADDR));
      // Issue beats writeback: a new producer issued in the old one's writeback cycle keeps it busy.
      assign busy_d[gi] = set_r ? 1'b1 : (clr_r ? 1'b0 : busy_q[gi]);
    end
  endgenerate

  always_comb begin
    busy_cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_cnt_d = busy_cnt_d + {{AW{1'b0}}, busy_d[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign bus.busy_cnt = busy_cnt_q;

  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [AW-1:0] ra;
      logic [DW-1:0] rd;
      logic          zero_hit;
      assign ra       = bus.raddr[gi*AW +: AW];
      assign zero_hit = ZERO_REG && (ra == '0);

      // Bypass priority mirrors write priority, so the forwarded value is what gets stored.
      always_comb begin
        rd = regs_q[ra];
        if (BYPASS && !reset) begin
          if (wr0_ok && (bus.wa0 == ra)) rd = bus.wd0;
          if (wr1_ok && (bus.wa1 == ra)) rd = bus.wd1;
        end
        if (zero_hit) rd = '0;
      end

      assign bus.rdata[gi*DW +: DW] = rd;
      assign bus.rbusy[gi]          = busy_q[ra] && !zero_hit;
    end
  endgenerate

`ifdef REG_FILE_MP_TRACE_EN
  always @(posedge clk) begin
    if (!reset) begin
      if (wr0_ok && !(wr1_ok && (bus.wa1 == bus.wa0)))
        $display("%d@port%0d: $%d <= %h", $time, 0, bus.wa0, bus.wd0);
      if (wr1_ok)
        $display("%d@port%0d: $%d <= %h", $time, 1, bus.wa1, bus.wd1);
    end
  end
`else
  // Trace disabled: the design produces no simulation output.
`endif

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: two instances (bypass+zero-reg, and plain) driven
// with identical stimulus and compared against array-based reference models.
module tb_reg_file_mp;
  localparam int DW     = 32;
  localparam int AW     = 5;
  localparam int NUM_RD = 3;
  localparam int DEPTH  = 1 << AW;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  reg_file_mp_if #(.DW(DW), .AW(AW), .NUM_RD(NUM_RD)) bus_a ();
  reg_file_mp_if #(.DW(DW), .AW(AW), .NUM_RD(NUM_RD)) bus_b ();

  assign bus_b.raddr    = bus_a.raddr;
  assign bus_b.we0      = bus_a.we0;
  assign bus_b.wa0      = bus_a.wa0;
  assign bus_b.wd0      = bus_a.wd0;
  assign bus_b.we1      = bus_a.we1;
  assign bus_b.wa1      = bus_a.wa1;
  assign bus_b.wd1      = bus_a.wd1;
  assign bus_b.iss_en   = bus_a.iss_en;
  assign bus_b.iss_addr = bus_a.iss_addr;

  reg_file_mp #(.DW(DW), .AW(AW), .NUM_RD(NUM_RD), .BYPASS(1'b1), .ZERO_REG(1'b1)) u_dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.slave)
  );
  reg_file_mp #(.DW(DW), .AW(AW), .NUM_RD(NUM_RD), .BYPASS(1'b0), .ZERO_REG(1'b0)) u_dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.slave)
  );

  // Reference models: a = bypass + zero register, b = plain array
  logic [DW-1:0] mem_a [DEPTH];
  logic [DW-1:0] mem_b [DEPTH];
  bit            busy_a [DEPTH];
  bit            busy_b [DEPTH];

  function automatic logic [AW-1:0] ra(input int k);
    return bus_a.raddr[k*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] exp_rd(input bit cfg_a, input logic [AW-1:0] addr);
    if (!cfg_a) return mem_b[addr];
    if (addr == '0) return '0;
    if (!reset && bus_a.we1 && bus_a.wa1 == addr) return bus_a.wd1;
    if (!reset && bus_a.we0 && bus_a.wa0 == addr) return bus_a.wd0;
    return mem_a[addr];
  endfunction

  function automatic logic exp_busy(input bit cfg_a, input logic [AW-1:0] addr);
    if (cfg_a) return (addr != '0) && busy_a[addr];
    return busy_b[addr];
  endfunction

  function automatic logic [AW:0] exp_cnt(input bit cfg_a);
    logic [AW:0] c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (cfg_a ? busy_a[i] : busy_b[i]) c = c + 1'b1;
    end
    return c;
  endfunction

  // Apply the effect of the current inputs as one clock edge would.
  task automatic model_step();
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_a[i] = '0; mem_b[i] = '0; busy_a[i] = 0; busy_b[i] = 0;
      end
    end else begin
      if (bus_a.we0) begin
        if (bus_a.wa0 != '0) mem_a[bus_a.wa0] = bus_a.wd0;
        mem_b[bus_a.wa0] = bus_a.wd0;
        busy_a[bus_a.wa0] = 0; busy_b[bus_a.wa0] = 0;
      end
      if (bus_a.we1) begin
        if (bus_a.wa1 != '0) mem_a[bus_a.wa1] = bus_a.wd1;
        mem_b[bus_a.wa1] = bus_a.wd1;
        busy_a[bus_a.wa1] = 0; busy_b[bus_a.wa1] = 0;
      end
      if (bus_a.iss_en) begin
        if (bus_a.iss_addr != '0) busy_a[bus_a.iss_addr] = 1;
        busy_b[bus_a.iss_addr] = 1;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    reset          = 1'b0;
    bus_a.we0      = 1'b0; bus_a.wa0 = '0; bus_a.wd0 = '0;
    bus_a.we1      = 1'b0; bus_a.wa1 = '0; bus_a.wd1 = '0;
    bus_a.iss_en   = 1'b0; bus_a.iss_addr = '0;
  endtask

  task automatic set_ra(input int k, input logic [AW-1:0] a);
    bus_a.raddr[k*AW +: AW] = a;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, DEPTH-1));
    return AW'($urandom_range(0, 7));
  endfunction

  task automatic test_reset();
    drive_idle();
    bus_a.raddr = '0;
    reset = 1'b1;
    bus_a.we0 = 1'b1; bus_a.wa0 = 5'd3; bus_a.wd0 = 32'hDEAD_BEEF;
    bus_a.iss_en = 1'b1; bus_a.iss_addr = 5'd3;
    tick();
    tick();
    drive_idle();
    for (int a = 0; a < DEPTH; a++) begin
      for (int k = 0; k < NUM_RD; k++) set_ra(k, AW'((a + k) % DEPTH));
      #1;
      for (int k = 0; k < NUM_RD; k++) begin
        checks += 4;
        if (bus_a.rdata[k*DW +: DW] !== '0) begin
          errors++; $display("FAIL reset_rdata_a port%0d addr %0d: got %h expected 0", k, ra(k), bus_a.rdata[k*DW +: DW]);
        end
        if (bus_b.rdata[k*DW +: DW] !== '0) begin
          errors++; $display("FAIL reset_rdata_b port%0d addr %0d: got %h expected 0", k, ra(k), bus_b.rdata[k*DW +: DW]);
        end
        if (bus_a.rbusy[k] !== 1'b0) begin
          errors++; $display("FAIL reset_rbusy_a port%0d: got %b expected 0", k, bus_a.rbusy[k]);
        end
        if (bus_b.rbusy[k] !== 1'b0) begin
          errors++; $display("FAIL reset_rbusy_b port%0d: got %b expected 0", k, bus_b.rbusy[k]);
        end
      end
    end
    checks += 2;
    if (bus_a.busy_cnt !== '0) begin
      errors++; $display("FAIL reset_busy_cnt_a: got %0d expected 0", bus_a.busy_cnt);
    end
    if (bus_b.busy_cnt !== '0) begin
      errors++; $display("FAIL reset_busy_cnt_b: got %0d expected 0", bus_b.busy_cnt);
    end
  endtask

  task automatic test_bypass();
    drive_idle();
    bus_a.raddr = '0;
    set_ra(2, 5'd5);
    bus_a.we0 = 1'b1; bus_a.wa0 = 5'd5; bus_a.wd0 = 32'h0000_1234;
    #1;
    checks += 2;
    if (bus_a.rdata[2*DW +: DW] !== 32'h0000_1234) begin
      errors++; $display("FAIL bypass_pre_a: got %h expected 00001234", bus_a.rdata[2*DW +: DW]);
    end
    if (bus_b.rdata[2*DW +: DW] !== 32'h0) begin
      errors++; $display("FAIL bypass_pre_b: got %h expected 00000000", bus_b.rdata[2*DW +: DW]);
    end
    tick();
    drive_idle();
    #1;
    checks += 2;
    if (bus_a.rdata[2*DW +: DW] !== 32'h0000_1234) begin
      errors++; $display("FAIL bypass_post_a: got %h expected 00001234", bus_a.rdata[2*DW +: DW]);
    end
    if (bus_b.rdata[2*DW +: DW] !== 32'h0000_1234) begin
      errors++; $display("FAIL bypass_post_b: got %h expected 00001234", bus_b.rdata[2*DW +: DW]);
    end
  endtask

  task automatic test_write_priority();
    drive_idle();
    bus_a.raddr = '0;
    set_ra(0, 5'd7);
    bus_a.we0 = 1'b1; bus_a.wa0 = 5'd7; bus_a.wd0 = 32'hAAAA_AAAA;
    bus_a.we1 = 1'b1; bus_a.wa1 = 5'd7; bus_a.wd1 = 32'h5555_5555;
    #1;
    checks++;
    if (bus_a.rdata[DW-1:0] !== 32'h5555_5555) begin
      errors++; $display("FAIL prio_bypass_a: got %h expected 55555555", bus_a.rdata[DW-1:0]);
    end
    tick();
    drive_idle();
    #1;
    checks += 2;
    if (bus_a.rdata[DW-1:0] !== 32'h5555_5555) begin
      errors++; $display("FAIL prio_stored_a: got %h expected 55555555", bus_a.rdata[DW-1:0]);
    end
    if (bus_b.rdata[DW-1:0] !== 32'h5555_5555) begin
      errors++; $display("FAIL prio_stored_b: got %h expected 55555555", bus_b.rdata[DW-1:0]);
    end
  endtask

  task automatic test_zero_reg();
    drive_idle();
    bus_a.raddr = '0;
    bus_a.we1 = 1'b1; bus_a.wa1 = 5'd0; bus_a.wd1 = 32'hFFFF_FFFF;
    bus_a.iss_en = 1'b1; bus_a.iss_addr = 5'd0;
    #1;
    checks += 2;
    if (bus_a.rdata[DW +: DW] !== 32'h0) begin
      errors++; $display("FAIL zero_pre_rdata_a: got %h expected 00000000", bus_a.rdata[DW +: DW]);
    end
    if (bus_a.rbusy[1] !== 1'b0) begin
      errors++; $display("FAIL zero_pre_rbusy_a: got %b expected 0", bus_a.rbusy[1]);
    end
    tick();
    drive_idle();
    #1;
    checks += 6;
    if (bus_a.rdata[DW +: DW] !== 32'h0) begin
      errors++; $display("FAIL zero_post_rdata_a: got %h expected 00000000", bus_a.rdata[DW +: DW]);
    end
    if (bus_a.rbusy[1] !== 1'b0) begin
      errors++; $display("FAIL zero_post_rbusy_a: got %b expected 0", bus_a.rbusy[1]);
    end
    if (bus_a.busy_cnt !== 6'd0) begin
      errors++; $display("FAIL zero_busy_cnt_a: got %0d expected 0", bus_a.busy_cnt);
    end
    if (bus_b.rdata[DW +: DW] !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL zero_ordinary_rdata_b: got %h expected ffffffff", bus_b.rdata[DW +: DW]);
    end
    if (bus_b.rbusy[1] !== 1'b1) begin
      errors++; $display("FAIL zero_ordinary_rbusy_b: got %b expected 1", bus_b.rbusy[1]);
    end
    if (bus_b.busy_cnt !== 6'd1) begin
      errors++; $display("FAIL zero_ordinary_busy_cnt_b: got %0d expected 1", bus_b.busy_cnt);
    end
    // Retire the ordinary-instance r0 so both instances start the scoreboard test clean.
    bus_a.we0 = 1'b1; bus_a.wa0 = 5'd0; bus_a.wd0 = '0;
    tick();
    drive_idle();
  endtask

  task automatic test_scoreboard();
    drive_idle();
    bus_a.raddr = '0;
    set_ra(0, 5'd3);
    set_ra(1, 5'd9);
    bus_a.iss_en = 1'b1; bus_a.iss_addr = 5'd3;
    tick();
    bus_a.iss_addr = 5'd9;
    tick();
    drive_idle();
    #1;
    checks += 4;
    if (bus_a.busy_cnt !== 6'd2) begin
      errors++; $display("FAIL sb_two_cnt_a: got %0d expected 2", bus_a.busy_cnt);
    end
    if (bus_b.busy_cnt !== 6'd2) begin
      errors++; $display("FAIL sb_two_cnt_b: got %0d expected 2", bus_b.busy_cnt);
    end
    if (bus_a.rbusy[0] !== 1'b1) begin
      errors++; $display("FAIL sb_r3_busy_a: got %b expected 1", bus_a.rbusy[0]);
    end
    if (bus_b.rbusy[0] !== 1'b1) begin
      errors++; $display("FAIL sb_r3_busy_b: got %b expected 1", bus_b.rbusy[0]);
    end
    bus_a.we1 = 1'b1; bus_a.wa1 = 5'd3; bus_a.wd1 = $urandom();
    #1;
    checks++;
    if (bus_a.rbusy[0] !== 1'b1) begin
      errors++; $display("FAIL sb_no_clear_bypass_a: got %b expected 1", bus_a.rbusy[0]);
    end
    tick();
    drive_idle();
    #1;
    checks += 3;
    if (bus_a.busy_cnt !== 6'd1) begin
      errors++; $display("FAIL sb_wb_cnt_a: got %0d expected 1", bus_a.busy_cnt);
    end
    if (bus_a.rbusy[0] !== 1'b0) begin
      errors++; $display("FAIL sb_wb_r3_a: got %b expected 0", bus_a.rbusy[0]);
    end
    if (bus_b.busy_cnt !== 6'd1) begin
      errors++; $display("FAIL sb_wb_cnt_b: got %0d expected 1", bus_b.busy_cnt);
    end
    bus_a.we0 = 1'b1; bus_a.wa0 = 5'd9; bus_a.wd0 = $urandom();
    bus_a.iss_en = 1'b1; bus_a.iss_addr = 5'd9;
    tick();
    drive_idle();
    #1;
    checks += 3;
    if (bus_a.busy_cnt !== 6'd1) begin
      errors++; $display("FAIL sb_reissue_cnt_a: got %0d expected 1", bus_a.busy_cnt);
    end
    if (bus_a.rbusy[1] !== 1'b1) begin
      errors++; $display("FAIL sb_reissue_r9_a: got %b expected 1", bus_a.rbusy[1]);
    end
    if (bus_b.rbusy[1] !== 1'b1) begin
      errors++; $display("FAIL sb_reissue_r9_b: got %b expected 1", bus_b.rbusy[1]);
    end
  endtask

  task automatic test_reset_mid();
    drive_idle();
    bus_a.raddr = '0;
    set_ra(0, 5'd4);
    bus_a.iss_en = 1'b1; bus_a.iss_addr = 5'd4;
    tick();
    drive_idle();
    #1;
    checks++;
    if (bus_a.rbusy[0] !== 1'b1) begin
      errors++; $display("FAIL rstmid_issue_a: got %b expected 1", bus_a.rbusy[0]);
    end
    reset = 1'b1;
    bus_a.we0 = 1'b1; bus_a.wa0 = 5'd4; bus_a.wd0 = 32'h0000_0077;
    #1;
    checks++;
    if (bus_a.rdata[DW-1:0] !== exp_rd(1'b1, 5'd4)) begin
      errors++; $display("FAIL rstmid_no_bypass_a: got %h expected %h", bus_a.rdata[DW-1:0], exp_rd(1'b1, 5'd4));
    end
    tick();
    drive_idle();
    #1;
    checks += 6;
    if (bus_a.rdata[DW-1:0] !== 32'h0) begin
      errors++; $display("FAIL rstmid_r4_a: got %h expected 00000000", bus_a.rdata[DW-1:0]);
    end
    if (bus_b.rdata[DW-1:0] !== 32'h0) begin
      errors++; $display("FAIL rstmid_r4_b: got %h expected 00000000", bus_b.rdata[DW-1:0]);
    end
    if (bus_a.rbusy[0] !== 1'b0) begin
      errors++; $display("FAIL rstmid_rbusy_a: got %b expected 0", bus_a.rbusy[0]);
    end
    if (bus_b.rbusy[0] !== 1'b0) begin
      errors++; $display("FAIL rstmid_rbusy_b: got %b expected 0", bus_b.rbusy[0]);
    end
    if (bus_a.busy_cnt !== 6'd0) begin
      errors++; $display("FAIL rstmid_cnt_a: got %0d expected 0", bus_a.busy_cnt);
    end
    if (bus_b.busy_cnt !== 6'd0) begin
      errors++; $display("FAIL rstmid_cnt_b: got %0d expected 0", bus_b.busy_cnt);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      reset          = ($urandom_range(0, 49) == 0);
      bus_a.we0      = 1'($urandom_range(0, 1));
      bus_a.wa0      = rand_addr();
      bus_a.wd0      = $urandom();
      bus_a.we1      = 1'($urandom_range(0, 1));
      bus_a.wa1      = ($urandom_range(0, 3) == 0) ? bus_a.wa0 : rand_addr();
      bus_a.wd1      = $urandom();
      bus_a.iss_en   = 1'($urandom_range(0, 1));
      bus_a.iss_addr = rand_addr();
      for (int k = 0; k < NUM_RD; k++) set_ra(k, rand_addr());
      #1;
      for (int k = 0; k < NUM_RD; k++) begin
        checks += 4;
        if (bus_a.rdata[k*DW +: DW] !== exp_rd(1'b1, ra(k))) begin
          errors++; $display("FAIL rand_rdata_a n%0d port%0d addr %0d: got %h expected %h", n, k, ra(k), bus_a.rdata[k*DW +: DW], exp_rd(1'b1, ra(k)));
        end
        if (bus_b.rdata[k*DW +: DW] !== exp_rd(1'b0, ra(k))) begin
          errors++; $display("FAIL rand_rdata_b n%0d port%0d addr %0d: got %h expected %h", n, k, ra(k), bus_b.rdata[k*DW +: DW], exp_rd(1'b0, ra(k)));
        end
        if (bus_a.rbusy[k] !== exp_busy(1'b1, ra(k))) begin
          errors++; $display("FAIL rand_rbusy_a n%0d port%0d addr %0d: got %b expected %b", n, k, ra(k), bus_a.rbusy[k], exp_busy(1'b1, ra(k)));
        end
        if (bus_b.rbusy[k] !== exp_busy(1'b0, ra(k))) begin
          errors++; $display("FAIL rand_rbusy_b n%0d port%0d addr %0d: got %b expected %b", n, k, ra(k), bus_b.rbusy[k], exp_busy(1'b0, ra(k)));
        end
      end
      checks += 2;
      if (bus_a.busy_cnt !== exp_cnt(1'b1)) begin
        errors++; $display("FAIL rand_cnt_a n%0d: got %0d expected %0d", n, bus_a.busy_cnt, exp_cnt(1'b1));
      end
      if (bus_b.busy_cnt !== exp_cnt(1'b0)) begin
        errors++; $display("FAIL rand_cnt_b n%0d: got %0d expected %0d", n, bus_b.busy_cnt, exp_cnt(1'b0));
      end
      $display("rand n%0d: rst=%0b we0=%0b wa0=%0d we1=%0b wa1=%0d iss=%0b ia=%0d cnt_a=%0d cnt_b=%0d",
               n, reset, bus_a.we0, bus_a.wa0, bus_a.we1, bus_a.wa1, bus_a.iss_en, bus_a.iss_addr,
               bus_a.busy_cnt, bus_b.busy_cnt);
      tick();
    end
    drive_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive_idle();
    bus_a.raddr = '0;
    test_reset();
    test_bypass();
    test_write_priority();
    test_zero_reg();
    test_scoreboard();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
